// File: rtl/cordic_sincos_param.sv
// Iterative CORDIC sine/cosine of a signed fixed-point angle over [-pi, pi].
// Quadrant folding in front, one micro-rotation per cycle, rounding and saturation at the end.
module cordic_sincos_param #(
  parameter int WIDTH = 12,
  parameter int FRAC  = 10,
  parameter int GUARD = 3,
  parameter int ITER  = 11
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic signed [WIDTH:0]   angle_in,
  output logic                    ready_out,
  output logic signed [WIDTH-1:0] sin_out,
  output logic signed [WIDTH-1:0] cos_out,
  output logic                    range_err_out
);
  localparam int IW = WIDTH + GUARD + 2;
  localparam int FI = FRAC + GUARD;

  localparam longint K_Q30       = 64'sd652032874;
  localparam longint PI_Q30      = 64'sd3373259426;
  localparam longint HALF_PI_Q30 = 64'sd1686629713;

  // Rescale a Q1.30 constant to f fraction bits, rounding to nearest.
  function automatic longint scale_q30(input longint v, input int f);
    int sh;
    sh = 30 - f;
    if (sh <= 0) return v <<< (-sh);
    return (v + (longint'(1) <<< (sh - 1))) >>> sh;
  endfunction

  function automatic longint atan_q30(input int i);
    case (i)
      0:       return 64'sd843314857;
      1:       return 64'sd497837829;
      2:       return 64'sd263043837;
      3:       return 64'sd133525159;
      4:       return 64'sd67021687;
      5:       return 64'sd33543516;
      6:       return 64'sd16775851;
      7:       return 64'sd8388437;
      8:       return 64'sd4194283;
      9:       return 64'sd2097149;
      10:      return 64'sd1048576;
      11:      return 64'sd524288;
      12:      return 64'sd262144;
      13:      return 64'sd131072;
      14:      return 64'sd65536;
      15:      return 64'sd32768;
      default: return 64'sd0;
    endcase
  endfunction

  localparam longint K_L     = scale_q30(K_Q30, FI);
  localparam longint PI_L    = scale_q30(PI_Q30, FI);
  localparam longint MPI_L   = -PI_L;
  localparam longint HALF_L  = scale_q30(HALF_PI_Q30, FI);
  localparam longint MHALF_L = -HALF_L;
  localparam longint PIA_L   = scale_q30(PI_Q30, FRAC);
  localparam longint MPIA_L  = -PIA_L;
  localparam longint ONE_L   = longint'(1) <<< FRAC;
  localparam longint MONE_L  = -ONE_L;
  localparam longint RND_L   = (GUARD > 0) ? (longint'(1) <<< (GUARD - 1)) : 64'sd0;

  localparam logic signed [IW-1:0]  K_I      = K_L[IW-1:0];
  localparam logic signed [IW-1:0]  PI_I     = PI_L[IW-1:0];
  localparam logic signed [IW-1:0]  MPI_I    = MPI_L[IW-1:0];
  localparam logic signed [IW-1:0]  HALF_I   = HALF_L[IW-1:0];
  localparam logic signed [IW-1:0]  MHALF_I  = MHALF_L[IW-1:0];
  localparam logic signed [IW-1:0]  ONE_I    = ONE_L[IW-1:0];
  localparam logic signed [IW-1:0]  MONE_I   = MONE_L[IW-1:0];
  localparam logic signed [IW-1:0]  RND_I    = RND_L[IW-1:0];
  localparam logic signed [WIDTH:0] PI_A     = PIA_L[WIDTH:0];
  localparam logic signed [WIDTH:0] NEG_PI_A = MPIA_L[WIDTH:0];

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ROTATE = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

  logic signed [IW-1:0] atan_tab [16];
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_atan
      localparam longint ATAN_L = scale_q30(atan_q30(gi), FI);
      assign atan_tab[gi] = ATAN_L[IW-1:0];
    end
  endgenerate

  // Round away the guard bits, saturate to +-1.0 and optionally negate.
  function automatic logic signed [WIDTH-1:0] finish_val(input logic signed [IW-1:0] v,
                                                         input logic negate);
    logic signed [IW-1:0] r;
    r = (v + RND_I) >>> GUARD;
    if (r > ONE_I) r = ONE_I;
    else if (r < MONE_I) r = MONE_I;
    if (negate) r = -r;
    return r[WIDTH-1:0];
  endfunction

  logic [1:0]              state_reg, state_next;
  logic signed [IW-1:0]    x_reg, x_next, y_reg, y_next, z_reg, z_next;
  logic [3:0]              iter_reg, iter_next;
  logic                    neg_cos_reg, neg_cos_next;
  logic                    ready_reg, ready_next, err_reg, err_next;
  logic signed [WIDTH-1:0] sin_reg, sin_next, cos_reg, cos_next;
  logic signed [WIDTH:0]   clamped;
  logic                    clamp_hit;
  logic signed [IW-1:0]    a_int, x_sh, y_sh;

  always_comb begin
    state_next   = state_reg;
    x_next       = x_reg;
    y_next       = y_reg;
    z_next       = z_reg;
    iter_next    = iter_reg;
    neg_cos_next = neg_cos_reg;
    ready_next   = ready_reg;
    err_next     = err_reg;
    sin_next     = sin_reg;
    cos_next     = cos_reg;
    clamped      = angle_in;
    clamp_hit    = 1'b0;
    if (angle_in > PI_A) begin
      clamped   = PI_A;
      clamp_hit = 1'b1;
    end else if (angle_in < NEG_PI_A) begin
      clamped   = NEG_PI_A;
      clamp_hit = 1'b1;
    end
    a_int = {{(IW-WIDTH-1){clamped[WIDTH]}}, clamped} <<< GUARD;
    x_sh  = x_reg >>> iter_reg;
    y_sh  = y_reg >>> iter_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          err_next   = clamp_hit;
          ready_next = 1'b0;
          x_next     = K_I;
          y_next     = '0;
          iter_next  = '0;
          state_next = ROTATE;
          // Fold outer quadrants onto [-pi/2, pi/2]; cosine changes sign there.
          if (a_int > HALF_I) begin
            z_next       = PI_I - a_int;
            neg_cos_next = 1'b1;
          end else if (a_int < MHALF_I) begin
            z_next       = MPI_I - a_int;
            neg_cos_next = 1'b1;
          end else begin
            z_next       = a_int;
            neg_cos_next = 1'b0;
          end
        end
      end
      ROTATE: begin
        if (!z_reg[IW-1]) begin
          x_next = x_reg - y_sh;
          y_next = y_reg + x_sh;
          z_next = z_reg - atan_tab[iter_reg];
        end else begin
          x_next = x_reg + y_sh;
          y_next = y_reg - x_sh;
          z_next = z_reg + atan_tab[iter_reg];
        end
        iter_next = iter_reg + 4'd1;
        if (iter_reg == 4'(ITER - 1)) state_next = FINISH;
      end
      FINISH: begin
        cos_next   = finish_val(x_reg, neg_cos_reg);
        sin_next   = finish_val(y_reg, 1'b0);
        ready_next = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= IDLE;
      x_reg       <= '0;
      y_reg       <= '0;
      z_reg       <= '0;
      iter_reg    <= '0;
      neg_cos_reg <= 1'b0;
      ready_reg   <= 1'b0;
      err_reg     <= 1'b0;
      sin_reg     <= '0;
      cos_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      x_reg       <= x_next;
      y_reg       <= y_next;
      z_reg       <= z_next;
      iter_reg    <= iter_next;
      neg_cos_reg <= neg_cos_next;
      ready_reg   <= ready_next;
      err_reg     <= err_next;
      sin_reg     <= sin_next;
      cos_reg     <= cos_next;
    end
  end

  assign ready_out     = ready_reg;
  assign sin_out       = sin_reg;
  assign cos_out       = cos_reg;
  assign range_err_out = err_reg;
endmodule

// File: doc/cordic_sincos_param.md
# cordic_sincos_param

Parametrised iterative CORDIC sine/cosine generator. It succeeds the fixed 12-bit first-quadrant unit with four additions:
- configurable output width, fraction bits, guard bits and iteration count;
- full-circle input range [-π, π] via quadrant folding;
- output saturation and rounding;
- an out-of-range flag.

It sits wherever a sin/cos pair of a fixed-point angle is needed and keeps the start/ready_out handshake of the previous generation, so existing error-statistics benches reuse unchanged.

## Interface
- WIDTH, 12: output width (signed two's complement).
- FRAC, 10: fraction bits of angle and outputs (LSB = 2^-FRAC).
- GUARD, 3: extra internal fraction bits in x/y/z datapath.
- ITER, 11: CORDIC micro-rotations, legal 4..16.
- clock  in  1  single clock, all logic on posedge.
- reset  in  1  synchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- angle_in  in  WIDTH+1  signed radians, FRAC fraction bits; sampled on the accepting edge only.
- ready_out  out  1  high for the cycle(s) holding a fresh result; low while computing.
- sin_out  out  WIDTH  signed, FRAC fraction bits.
- cos_out  out  WIDTH  signed, FRAC fraction bits.
- range_err_out  out  1  the last accepted angle exceeded ±π and was clamped.

## Operation
- Constants are Q1.30 literals (atan(2^-i) for i=0..15, K=0.6072529350, π, π/2) and are shifted at elaboration to FRAC+GUARD fraction bits. PI_Q = round(π·2^FRAC) = 3217 for the defaults.
- Internal regs x, y, z are WIDTH+GUARD+2 bits signed. There is also a 4-bit iter counter and a neg_cos flag.
- States are IDLE, ROTATE and FINISH.
- IDLE + start=1, accepting edge:
  - clamp angle to [-PI_Q, PI_Q] and set range_err_out if clamping occurred;
  - fold: a > π/2 → z = π−a, neg_cos=1; a < −π/2 → z = −π−a, neg_cos=1; else z = a, neg_cos=0;
  - x=K, y=0, iter=0, ready_out=0, go to ROTATE.
- ROTATE, one micro-rotation per cycle:
  - d = (z≥0) ? +1 : −1;
  - x' = x − d·(y>>>iter), y' = y + d·(x>>>iter), z' = z − d·atan[iter];
  - all shifts are arithmetic; iter increments. After the micro-rotation with iter=ITER−1, go to FINISH.
- FINISH:
  - round each of x and y by adding 2^(GUARD−1), then shift right arithmetically by GUARD;
  - saturate to [−2^FRAC, +2^FRAC];
  - cos_out = neg_cos ? −x : x, sin_out = y;
  - ready_out=1, go to IDLE.
- IDLE + start=0: hold outputs and ready_out unchanged.
- start while in ROTATE or FINISH is ignored, and angle_in changes during computation have no effect.
- Accuracy for the defaults: |error| ≤ 2 LSB on both outputs over the full range; mean error within ±0.5 LSB; MSE ≤ 1 LSB².

## Timing
- Reset values: ready_out=0, sin_out=0, cos_out=0, range_err_out=0, state IDLE. Reset overrides everything, including mid-ROTATE. The aborted result is never presented.
- Start sampled high at edge N (IDLE): ready_out low from N. Results and ready_out=1 appear after edge N+ITER+1. Latency is ITER+1 cycles, 12 for the defaults.
- When start is held continuously high, ready_out is high for exactly one cycle. The next computation is accepted on the following edge, so the throughput is one result per ITER+2 cycles.
- When start is low after FINISH, ready_out stays high and the outputs stay stable until the next accepted start.
- range_err_out updates only on the accepting edge and stays valid with its result.
- reset and start both high on the same edge: reset wins and nothing is accepted.

## Test plan
- Reset, then start with angle_in=0: after 12 cycles ready_out rises; sin_out=0±1, cos_out=1024±1, range_err_out=0.
- angle_in=1608 (π/2): sin_out=1024±2 with no overflow past 1024, cos_out=0±2. angle_in=−1608: sin_out=−1024±2.
- angle_in=3217 (π): sin_out=0±2, cos_out=−1024±2. angle_in=4000: range_err_out=1 and the outputs equal the π case.
- Start held high; sweep −3217..3217 by 1: every ready_out rising edge gives |error| ≤ 2 LSB against a real-valued model; final MSE ≤ 1 LSB².
- Pulse start and change angle_in on cycle 5 of a computation: result matches the originally sampled angle and no second computation begins.
- Assert reset on cycle 6 of ROTATE: the next cycle has ready_out=0 and outputs=0. A subsequent start with 804 (π/4) gives sin_out = cos_out = 724±2.
